// File: rtl/data_sync_if.sv
// Source-to-destination bus bundle for the data_sync clock-domain crossing.
interface data_sync_if #(
  parameter int BUS_WIDTH = 8
);
  logic                 EN;
  logic [BUS_WIDTH-1:0] UNSYNC_BUS;
  logic                 enable_pulse;
  logic [BUS_WIDTH-1:0] SYNC_BUS;

  modport master (output EN, output UNSYNC_BUS, input enable_pulse, input SYNC_BUS);
  modport slave  (input EN, input UNSYNC_BUS, output enable_pulse, output SYNC_BUS);
endinterface

// File: rtl/data_sync.sv
// Multi-flop bus synchronizer: EN crosses through a flop chain, and its rising edge
// loads UNSYNC_BUS into SYNC_BUS and raises enable_pulse for one cycle.
module data_sync #(
  parameter int NUM_STAGES = 3,
  parameter int BUS_WIDTH  = 8
) (
  input  logic         CLK,
  input  logic         RST,
  data_sync_if.slave   bus
);

  logic [NUM_STAGES-1:0] sync;
  logic                  pg_ff;
  logic                  sync_en;
  logic                  pulse_c;

  assign sync_en = sync[NUM_STAGES-1];
  // Rising edge of the synchronized enable; the bus is stable by the time it fires.
  assign pulse_c = sync_en & ~pg_ff;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync             <= '0;
      pg_ff            <= 1'b0;
      bus.enable_pulse <= 1'b0;
      bus.SYNC_BUS     <= '0;
    end else begin
      sync             <= {sync[NUM_STAGES-2:0], bus.EN};
      pg_ff            <= sync_en;
      bus.enable_pulse <= pulse_c;
      if (pulse_c)
        bus.SYNC_BUS <= bus.UNSYNC_BUS;
    end
  end

endmodule

// File: tb/tb_data_sync.sv
// Directed bench for data_sync: default instance plus NUM_STAGES=2/4 sweep instances.
module tb_data_sync;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;
  string phase;

  data_sync_if #(.BUS_WIDTH(8))  bif();
  data_sync_if #(.BUS_WIDTH(16)) bif2();
  data_sync_if #(.BUS_WIDTH(16)) bif4();

  data_sync #(.NUM_STAGES(3), .BUS_WIDTH(8))  dut  (.CLK(CLK), .RST(RST), .bus(bif.slave));
  data_sync #(.NUM_STAGES(2), .BUS_WIDTH(16)) dut2 (.CLK(CLK), .RST(RST), .bus(bif2.slave));
  data_sync #(.NUM_STAGES(4), .BUS_WIDTH(16)) dut4 (.CLK(CLK), .RST(RST), .bus(bif4.slave));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check the default instance's outputs.
  task automatic cyc(input logic pulse, input logic [7:0] data);
    @(negedge CLK);
    chk({phase, ".pulse"}, {31'b0, bif.enable_pulse}, {31'b0, pulse});
    chk({phase, ".bus"},   {24'b0, bif.SYNC_BUS},     {24'b0, data});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    bif.EN  = 1'b0; bif.UNSYNC_BUS  = 8'hFF;
    bif2.EN = 1'b0; bif2.UNSYNC_BUS = 16'h0;
    bif4.EN = 1'b0; bif4.UNSYNC_BUS = 16'h0;

    // Reset held two edges with a non-zero bus present
    phase = "reset";
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    RST = 1'b0;
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);

    // Single transfer: pulse on the 4th edge after EN rises
    phase = "single";
    bif.EN = 1'b1; bif.UNSYNC_BUS = 8'h08;
    repeat (3) cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h08);
    bif.EN = 1'b0;
    cyc(1'b0, 8'h08);

    // Back-to-back after one low sample
    phase = "b2b";
    bif.EN = 1'b1; bif.UNSYNC_BUS = 8'h07;
    repeat (3) cyc(1'b0, 8'h08);
    cyc(1'b1, 8'h07);
    bif.EN = 1'b0;
    repeat (4) cyc(1'b0, 8'h07);

    // EN stuck high, bus changing every cycle: single capture of the value at the pulse edge
    phase = "stuck";
    bif.EN = 1'b1; bif.UNSYNC_BUS = 8'h10;
    for (int i = 1; i <= 20; i++) begin
      cyc(i == 4, (i >= 4) ? 8'h13 : 8'h07);
      bif.UNSYNC_BUS = 8'h10 + 8'(i);
    end
    bif.EN = 1'b0;
    repeat (4) cyc(1'b0, 8'h13);

    // Reset in the middle of a transfer, EN still high after release
    phase = "midrst";
    bif.EN = 1'b1; bif.UNSYNC_BUS = 8'h5A;
    cyc(1'b0, 8'h13);
    RST = 1'b1;
    cyc(1'b0, 8'h00);
    RST = 1'b0;
    repeat (3) cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h5A);
    repeat (3) cyc(1'b0, 8'h5A);
    bif.EN = 1'b0;
    repeat (4) cyc(1'b0, 8'h5A);

    // Depth sweep: latency NUM_STAGES+1 edges for 2 and 4 stages
    phase = "sweep";
    bif2.EN = 1'b1; bif2.UNSYNC_BUS = 16'hBEEF;
    bif4.EN = 1'b1; bif4.UNSYNC_BUS = 16'hBEEF;
    for (int i = 1; i <= 7; i++) begin
      @(negedge CLK);
      chk("sweep2.pulse", {31'b0, bif2.enable_pulse}, {31'b0, i == 3});
      chk("sweep2.bus",   {16'b0, bif2.SYNC_BUS},     (i >= 3) ? 32'hBEEF : 32'h0);
      chk("sweep4.pulse", {31'b0, bif4.enable_pulse}, {31'b0, i == 5});
      chk("sweep4.bus",   {16'b0, bif4.SYNC_BUS},     (i >= 5) ? 32'hBEEF : 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sync.md
Name: data_sync

Overview:
- Multi-flop (MCP) bus synchronizer for a bus that crosses into the CLK domain with a qualifying enable.
- EN is synchronized through a NUM_STAGES flop chain, and its rising edge is detected as a one-cycle pulse.
- On that pulse, UNSYNC_BUS is captured into the SYNC_BUS register and enable_pulse is asserted for one cycle.
- Sits at the receiving side of a clock-domain crossing; the sender keeps the bus stable while EN is high.

Parameters:
- NUM_STAGES, 3, depth of the EN synchronizer flop chain; legal range ≥2.
- BUS_WIDTH, 8, width of UNSYNC_BUS and SYNC_BUS; legal range ≥1.

Ports:
- CLK  input  1  destination-domain clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  asynchronous enable qualifying UNSYNC_BUS; level signal.
- UNSYNC_BUS  input  BUS_WIDTH  data from the source domain; stable while EN high.
- enable_pulse  output  1  registered one-cycle pulse, high on the cycle SYNC_BUS updates.
- SYNC_BUS  output  BUS_WIDTH  registered synchronized data; holds last captured value.

Behaviour:
- All logic runs on the CLK rising edge. There are no latches and no combinational paths from inputs to outputs.
- Reset (RST=1 at an edge):
  - sync chain cleared to 0.
  - pulse-generator flop cleared to 0.
  - enable_pulse = 0.
  - SYNC_BUS = 0.
  - Reset takes priority over everything. Reset mid-transfer aborts the transfer with no pulse. A fresh EN rising edge is needed after reset releases, and a stuck-high EN produces one pulse once the chain refills.
- Synchronizer chain:
  - sync[0] <= EN; sync[i] <= sync[i-1] for i = 1..NUM_STAGES-1.
  - sync_en = sync[NUM_STAGES-1].
- Pulse generator:
  - pg_ff <= sync_en.
  - pulse_c = sync_en & ~pg_ff (rising-edge detect).
- Outputs:
  - enable_pulse <= pulse_c.
  - SYNC_BUS <= pulse_c ? UNSYNC_BUS : SYNC_BUS (hold otherwise).
- Latency: EN sampled high first at edge k.
  - enable_pulse goes high and SYNC_BUS loads at edge k+NUM_STAGES.
  - Both are visible NUM_STAGES+1 edges after EN's assertion when EN is raised mid-cycle, i.e. 4 edges for the default.
- enable_pulse width is exactly one cycle, regardless of how long EN stays high.
- EN held high continuously: only one pulse and one capture; SYNC_BUS stays constant thereafter.
- EN low for at least one sampling edge, then high again: a new rising edge is detected and produces a new pulse and capture with the same latency.
  - EN glitches shorter than a clock period may be missed; this is not an error.
- EN falling edge: no pulse, and SYNC_BUS unchanged.
- UNSYNC_BUS changes while no pulse is pending: no effect on SYNC_BUS.
- The capture value is UNSYNC_BUS as sampled at the pulse edge. The source must hold the bus stable from EN rise through NUM_STAGES+1 edges.

Test Plan:
- Reset: RST=1 for 2 edges with EN=0 and UNSYNC_BUS=0xFF -> SYNC_BUS=0x00 and enable_pulse=0 on all cycles during and after reset.
- Single transfer (NUM_STAGES=3): EN=1 and UNSYNC_BUS=8 mid-cycle, held 4 cycles, then EN=0:
  - enable_pulse=1 for exactly one cycle at the 4th edge after assertion;
  - SYNC_BUS=8 after that and held.
- Back-to-back transfer: after the previous case, EN low one cycle, then EN=1 with UNSYNC_BUS=7 held 4 cycles:
  - second one-cycle pulse;
  - SYNC_BUS=7 four edges after re-assertion.
- EN stuck high 20 cycles with UNSYNC_BUS changing each cycle -> exactly one pulse; SYNC_BUS equals the value present at the pulse edge and never changes afterwards.
- Reset mid-transfer: EN=1 with data 0x5A, RST=1 at the 2nd edge, then released with EN still high:
  - no pulse before reset;
  - after release, one pulse NUM_STAGES+1 edges later with SYNC_BUS=0x5A;
  - SYNC_BUS=0 in between.
- Parameter sweep NUM_STAGES=2 and 4, BUS_WIDTH=16: data 0xBEEF -> pulse latency equals NUM_STAGES+1 edges and SYNC_BUS=0xBEEF.
